// File: rtl/cvp14_pkg.sv
// Shared definitions for the CVP14 scalar core: opcodes, FSM states,
// instruction field positions and immediate sign-extension helpers.
package cvp14_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SLH  = 4'b1001;
  localparam logic [3:0] OP_SLD  = 4'b1010;
  localparam logic [3:0] OP_SST  = 4'b1011;
  localparam logic [3:0] OP_BZ   = 4'b1100;
  localparam logic [3:0] OP_J    = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1110;

  localparam int OP_LSB = 12;
  localparam int D_LSB  = 9;
  localparam int S_LSB  = 6;
  localparam int T_LSB  = 3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_LOADWB = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

  function automatic logic [15:0] sext12(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

endpackage

// File: rtl/cvp14_scalar_rf.sv
// Eight 16-bit scalar registers: two asynchronous read ports, one synchronous
// write port, cleared synchronously by rst.
module cvp14_scalar_rf
  import cvp14_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  raddr_a,
  input  logic [2:0]  raddr_b,
  output logic [15:0] rdata_a,
  output logic [15:0] rdata_b
);

  logic [15:0] scalar [8];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        scalar[i] <= 16'h0000;
      end
    end else if (we) begin
      scalar[waddr] <= wdata;
    end
  end

  assign rdata_a = scalar[raddr_a];
  assign rdata_b = scalar[raddr_b];

endmodule

// File: rtl/cvp14_core.sv
// CVP14 scalar core: multi-cycle FSM fetching 16-bit instructions from a
// single-port DRAM, with PC, IR, ALU, sticky overflow flag and bus decode.
module cvp14_core
  import cvp14_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic [15:0] DataIn,
  output logic [15:0] Addr,
  output logic        RD,
  output logic        WR,
  output logic [15:0] DataOut,
  output logic        V
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        v_q, v_d;

  logic [3:0]  op;
  logic [2:0]  fd, fs, ft;
  logic [15:0] ra, rb, alu_sum, alu_diff, ea;
  logic [2:0]  rb_addr;
  logic        add_ovf, sub_ovf;
  logic        rf_we;
  logic [15:0] rf_wdata;
  logic [15:0] bus_addr, bus_wdata;
  logic        bus_rd, bus_wr;

  assign op = ir_q[15:OP_LSB];
  assign fd = ir_q[D_LSB +: 3];
  assign fs = ir_q[S_LSB +: 3];
  assign ft = ir_q[T_LSB +: 3];

  // Register-register ops read St on port B; everything else needs Sd there.
  assign rb_addr = (op[3:2] == 2'b00) ? ft : fd;

  cvp14_scalar_rf scalar (
    .clk     (Clk1),
    .rst     (Reset),
    .we      (rf_we),
    .waddr   (fd),
    .wdata   (rf_wdata),
    .raddr_a (fs),
    .raddr_b (rb_addr),
    .rdata_a (ra),
    .rdata_b (rb)
  );

  assign alu_sum  = ra + rb;
  assign alu_diff = ra - rb;
  assign add_ovf  = (ra[15] == rb[15]) && (alu_sum[15]  != ra[15]);
  assign sub_ovf  = (ra[15] != rb[15]) && (alu_diff[15] != ra[15]);
  assign ea       = ra + sext6(ir_q[5:0]);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    v_d       = v_q;
    rf_we     = 1'b0;
    rf_wdata  = 16'h0000;
    bus_addr  = 16'h0000;
    bus_wdata = 16'h0000;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        bus_addr = pc_q;
        bus_rd   = 1'b1;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        ir_d    = DataIn;
        pc_d    = pc_q + 16'd1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (op)
          OP_ADD: begin rf_we = 1'b1; rf_wdata = alu_sum;  v_d = v_q | add_ovf; end
          OP_SUB: begin rf_we = 1'b1; rf_wdata = alu_diff; v_d = v_q | sub_ovf; end
          OP_AND: begin rf_we = 1'b1; rf_wdata = ra & rb; end
          OP_OR:  begin rf_we = 1'b1; rf_wdata = ra | rb; end
          OP_SLL: begin rf_we = 1'b1; rf_wdata = {rb[15:8], ir_q[7:0]}; end
          OP_SLH: begin rf_we = 1'b1; rf_wdata = {ir_q[7:0], rb[7:0]}; end
          OP_SLD: begin
            bus_addr = ea;
            bus_rd   = 1'b1;
            state_d  = ST_LOADWB;
          end
          OP_SST: begin
            bus_addr  = ea;
            bus_wdata = rb;
            bus_wr    = 1'b1;
          end
          OP_BZ: begin
            if (rb == 16'h0000) pc_d = pc_q + sext9(ir_q[8:0]);
            else                pc_d = pc_q;
          end
          OP_J:    pc_d    = pc_q + sext12(ir_q[11:0]);
          OP_HALT: state_d = ST_HALTED;
          default: state_d = ST_FETCH;
        endcase
      end
      ST_LOADWB: begin
        rf_we    = 1'b1;
        rf_wdata = DataIn;
        state_d  = ST_FETCH;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_FETCH;
    endcase
    // A reset cycle must leave the bus quiet and abort any pending write-back.
    if (Reset) begin
      rf_we     = 1'b0;
      bus_addr  = 16'h0000;
      bus_wdata = 16'h0000;
      bus_rd    = 1'b0;
      bus_wr    = 1'b0;
    end else begin
      rf_we = rf_we;
    end
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      v_q     <= v_d;
    end
  end

  assign Addr    = bus_addr;
  assign RD      = bus_rd;
  assign WR      = bus_wr;
  assign DataOut = bus_wdata;
  assign V       = v_q;

endmodule

// File: tb/tb_cvp14_core.sv
// Bench for cvp14_core: DRAM model plus directed scenarios and randomized
// programs checked against an instruction-level interpreter of the ISA.
module tb_cvp14_core;

  logic        Clk1 = 1'b0;
  logic        Reset;
  logic [15:0] DataIn;
  logic [15:0] Addr;
  logic        RD;
  logic        WR;
  logic [15:0] DataOut;
  logic        V;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem   [0:65535];
  logic [15:0] m_mem [0:65535];
  logic [15:0] m_s   [0:7];
  logic [15:0] m_pc;
  logic        m_v;
  logic        m_halted;

  int          wr_count;
  logic [15:0] wr_addr, wr_data;

  cvp14_core #(.RESET_PC(16'h0000)) UUT (
    .Clk1    (Clk1),
    .Reset   (Reset),
    .DataIn  (DataIn),
    .Addr    (Addr),
    .RD      (RD),
    .WR      (WR),
    .DataOut (DataOut),
    .V       (V)
  );

  always #5 Clk1 = ~Clk1;

  // DRAM model: one-cycle read latency, write on the WR edge
  always @(posedge Clk1) begin
    if (WR) mem[Addr] <= DataOut;
    DataIn <= mem[Addr];
  end

  function automatic logic [15:0] enc_r(input logic [3:0] op, input int d, input int s, input int t);
    logic [2:0] d3, s3, t3;
    d3 = d[2:0]; s3 = s[2:0]; t3 = t[2:0];
    return {op, d3, s3, t3, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input int d, input logic [7:0] imm);
    logic [2:0] d3;
    d3 = d[2:0];
    return {op, d3, 1'b0, imm};
  endfunction

  function automatic logic [15:0] enc_m(input logic [3:0] op, input int d, input int s, input logic [5:0] imm);
    logic [2:0] d3, s3;
    d3 = d[2:0]; s3 = s[2:0];
    return {op, d3, s3, imm};
  endfunction

  function automatic logic [15:0] enc_bz(input int d, input logic [8:0] off);
    logic [2:0] d3;
    d3 = d[2:0];
    return {4'hC, d3, off};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) begin
      mem[i]   = 16'h0000;
      m_mem[i] = 16'h0000;
    end
  endtask

  task automatic poke(input int a, input logic [15:0] v);
    mem[a]   = v;
    m_mem[a] = v;
  endtask

  task automatic start();
    Reset = 1'b1;
    @(negedge Clk1);
    @(negedge Clk1);
    Reset = 1'b0;
  endtask

  // The core is idle for at most two consecutive cycles unless halted
  task automatic run_to_halt(input string name);
    int idle, cyc;
    idle = 0; cyc = 0; wr_count = 0; wr_addr = 16'h0000; wr_data = 16'h0000;
    while (idle < 4 && cyc < 5000) begin
      #1;
      if (WR) begin wr_count++; wr_addr = Addr; wr_data = DataOut; end
      if (!RD && !WR) idle++; else idle = 0;
      cyc++;
      @(negedge Clk1);
    end
    checks++;
    if (idle < 4) begin
      errors++;
      $display("FAIL %s_halt_timeout: ran %0d cycles, required halt", name, cyc);
    end
  endtask

  // Instruction-level interpreter of the program currently in m_mem
  task automatic model_run();
    logic [15:0] ir, a, b, ea;
    logic [3:0] op;
    int d, s, t, r;
    for (int i = 0; i < 8; i++) m_s[i] = 16'h0000;
    m_pc = 16'h0000; m_v = 1'b0; m_halted = 1'b0;
    for (int step = 0; step < 2000 && !m_halted; step++) begin
      ir = m_mem[m_pc];
      m_pc = m_pc + 16'd1;
      op = ir[15:12]; d = int'(ir[11:9]); s = int'(ir[8:6]); t = int'(ir[5:3]);
      a = m_s[s]; b = m_s[t];
      ea = a + {{10{ir[5]}}, ir[5:0]};
      case (op)
        4'h0: begin r = int'($signed(a)) + int'($signed(b));
                if (r > 32767 || r < -32768) m_v = 1'b1;
                m_s[d] = a + b; end
        4'h1: begin r = int'($signed(a)) - int'($signed(b));
                if (r > 32767 || r < -32768) m_v = 1'b1;
                m_s[d] = a - b; end
        4'h2: m_s[d] = a & b;
        4'h3: m_s[d] = a | b;
        4'h8: m_s[d] = {m_s[d][15:8], ir[7:0]};
        4'h9: m_s[d] = {ir[7:0], m_s[d][7:0]};
        4'hA: m_s[d] = m_mem[ea];
        4'hB: m_mem[ea] = m_s[d];
        4'hC: if (m_s[d] == 16'h0000) m_pc = m_pc + {{7{ir[8]}}, ir[8:0]};
        4'hD: m_pc = m_pc + {{4{ir[11]}}, ir[11:0]};
        4'hE: m_halted = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    @(negedge Clk1);
    @(negedge Clk1);
    #1;
    checks++;
    if ({RD, WR} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b required 00", {RD, WR}); end
    checks++;
    if (Addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h required 0000", Addr); end
    checks++;
    if (DataOut !== 16'h0000) begin errors++; $display("FAIL reset_dataout: got %h required 0000", DataOut); end
    checks++;
    if (V !== 1'b0) begin errors++; $display("FAIL reset_v: got %b required 0", V); end
    @(negedge Clk1);
    Reset = 1'b0;
    #1;
    checks++;
    if (RD !== 1'b1 || Addr !== 16'h0000) begin
      errors++; $display("FAIL reset_first_fetch: got RD=%b Addr=%h required RD=1 Addr=0000", RD, Addr);
    end
    @(negedge Clk1);
  endtask

  task automatic test_sll_slh();
    clear_mem();
    poke(0, enc_i(4'h8, 0, 8'h34));
    poke(1, enc_i(4'h9, 0, 8'h12));
    poke(2, 16'hE000);
    start();
    run_to_halt("sll_slh");
    checks++;
    if (UUT.scalar.scalar[0] !== 16'h1234) begin
      errors++; $display("FAIL sll_slh_s0: got %h required 1234", UUT.scalar.scalar[0]);
    end
    checks++;
    if (UUT.pc_q !== 16'h0003) begin errors++; $display("FAIL halt_pc: got %h required 0003", UUT.pc_q); end
    checks++;
    if (RD !== 1'b0) begin errors++; $display("FAIL halted_rd: got %b required 0", RD); end
  endtask

  task automatic test_overflow();
    clear_mem();
    poke(0, enc_i(4'h8, 1, 8'hFF));
    poke(1, enc_i(4'h9, 1, 8'h7F));
    poke(2, enc_i(4'h8, 2, 8'h01));
    poke(3, enc_r(4'h0, 7, 1, 2));
    poke(4, enc_r(4'h1, 3, 2, 2));
    poke(5, 16'hE000);
    start();
    run_to_halt("overflow");
    checks++;
    if (UUT.scalar.scalar[7] !== 16'h8000) begin
      errors++; $display("FAIL add_wrap_s7: got %h required 8000", UUT.scalar.scalar[7]);
    end
    checks++;
    if (UUT.scalar.scalar[3] !== 16'h0000) begin
      errors++; $display("FAIL sub_s3: got %h required 0000", UUT.scalar.scalar[3]);
    end
    checks++;
    if (V !== 1'b1) begin errors++; $display("FAIL v_sticky: got %b required 1", V); end
  endtask

  task automatic test_load_store();
    clear_mem();
    poke(16'h0040, 16'hBEEF);
    poke(0, enc_i(4'h8, 4, 8'h40));
    poke(1, enc_m(4'hA, 5, 4, 6'd0));
    poke(2, enc_m(4'hB, 5, 4, 6'd1));
    poke(3, 16'hE000);
    start();
    run_to_halt("load_store");
    checks++;
    if (mem[16'h0041] !== 16'hBEEF) begin
      errors++; $display("FAIL store_mem41: got %h required beef", mem[16'h0041]);
    end
    checks++;
    if (wr_count !== 1) begin errors++; $display("FAIL store_wr_count: got %0d required 1", wr_count); end
    checks++;
    if (wr_addr !== 16'h0041 || wr_data !== 16'hBEEF) begin
      errors++; $display("FAIL store_bus: got addr=%h data=%h required addr=0041 data=beef", wr_addr, wr_data);
    end
  endtask

  task automatic test_branch(input logic taken);
    logic [15:0] e1, e2;
    clear_mem();
    if (taken) poke(0, 16'hF000);
    else       poke(0, enc_i(4'h8, 0, 8'h01));
    poke(1, enc_bz(0, 9'd2));
    poke(2, enc_i(4'h8, 1, 8'h11));
    poke(3, enc_i(4'h8, 2, 8'h22));
    poke(4, enc_i(4'h8, 3, 8'h33));
    poke(5, 16'hE000);
    start();
    run_to_halt("branch");
    e1 = taken ? 16'h0000 : 16'h0011;
    e2 = taken ? 16'h0000 : 16'h0022;
    checks++;
    if (UUT.scalar.scalar[1] !== e1 || UUT.scalar.scalar[2] !== e2) begin
      errors++; $display("FAIL bz_taken%0d_skip: got s1=%h s2=%h required s1=%h s2=%h",
                         taken, UUT.scalar.scalar[1], UUT.scalar.scalar[2], e1, e2);
    end
    checks++;
    if (UUT.scalar.scalar[3] !== 16'h0033) begin
      errors++; $display("FAIL bz_taken%0d_s3: got %h required 0033", taken, UUT.scalar.scalar[3]);
    end
  endtask

  task automatic test_jump();
    clear_mem();
    poke(0, 16'hDFFF);
    start();
    for (int c = 0; c < 15; c++) begin
      #1;
      checks++;
      if (RD !== (c % 3 == 0) || (RD && Addr !== 16'h0000)) begin
        errors++; $display("FAIL jump_loop_cycle%0d: got RD=%b Addr=%h required RD=%0d Addr=0000",
                           c, RD, Addr, (c % 3 == 0));
      end
      @(negedge Clk1);
    end
  endtask

  task automatic test_reset_mid_load();
    int cyc;
    clear_mem();
    poke(16'h0040, 16'hBEEF);
    poke(0, enc_i(4'h9, 1, 8'h7F));
    poke(1, enc_i(4'h8, 1, 8'hFF));
    poke(2, enc_i(4'h8, 2, 8'h01));
    poke(3, enc_r(4'h0, 3, 1, 2));
    poke(4, enc_i(4'h8, 4, 8'h40));
    poke(5, enc_m(4'hA, 5, 4, 6'd0));
    poke(6, 16'hE000);
    start();
    cyc = 0;
    #1;
    while (!(RD && Addr == 16'h0040) && cyc < 200) begin
      @(negedge Clk1); #1; cyc++;
    end
    checks++;
    if (cyc >= 200) begin errors++; $display("FAIL midload_reach: got no SLD exec, required one"); end
    checks++;
    if (V !== 1'b1) begin errors++; $display("FAIL midload_v_before: got %b required 1", V); end
    Reset = 1'b1;
    #1;
    checks++;
    if (RD !== 1'b0 || WR !== 1'b0 || Addr !== 16'h0000) begin
      errors++; $display("FAIL midload_reset_bus: got RD=%b WR=%b Addr=%h required 0 0 0000", RD, WR, Addr);
    end
    @(negedge Clk1);
    Reset = 1'b0;
    #1;
    checks++;
    if (RD !== 1'b1 || Addr !== 16'h0000 || V !== 1'b0) begin
      errors++; $display("FAIL midload_after: got RD=%b Addr=%h V=%b required 1 0000 0", RD, Addr, V);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (UUT.scalar.scalar[i] !== 16'h0000) begin
        errors++; $display("FAIL midload_s%0d: got %h required 0000", i, UUT.scalar.scalar[i]);
      end
    end
  endtask

  task automatic test_random(input int iter);
    int pc, d, kind, diffs;
    logic [3:0] nops [0:4];
    nops[0] = 4'h4; nops[1] = 4'h5; nops[2] = 4'h6; nops[3] = 4'h7; nops[4] = 4'hF;
    clear_mem();
    for (int a = 16'h01E0; a < 16'h0220; a++) poke(a, 16'($urandom));
    pc = 0;
    poke(pc++, enc_i(4'h9, 6, 8'h02));
    for (int r = 0; r < 8; r++) begin
      if (r != 6) begin
        poke(pc++, enc_i(4'h8, r, 8'($urandom)));
        poke(pc++, enc_i(4'h9, r, 8'($urandom)));
      end
    end
    for (int k = 0; k < 24; k++) begin
      d = $urandom_range(0, 6);
      if (d == 6) d = 7;
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3: poke(pc++, enc_r(4'(kind), d, $urandom_range(0, 7), $urandom_range(0, 7)));
        4: poke(pc++, enc_r(4'h0, d, $urandom_range(0, 7), $urandom_range(0, 7)));
        5: poke(pc++, enc_i($urandom_range(0, 1) ? 4'h8 : 4'h9, d, 8'($urandom)));
        6: poke(pc++, enc_m(4'hA, d, 6, 6'($urandom)));
        7, 8: poke(pc++, enc_m(4'hB, $urandom_range(0, 7), 6, 6'($urandom)));
        default: poke(pc++, {nops[$urandom_range(0, 4)], 12'($urandom)});
      endcase
    end
    poke(pc, 16'hE000);
    model_run();
    start();
    run_to_halt("random");
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (UUT.scalar.scalar[i] !== m_s[i]) begin
        errors++; $display("FAIL rand%0d_s%0d: got %h required %h", iter, i, UUT.scalar.scalar[i], m_s[i]);
      end
    end
    checks++;
    if (V !== m_v) begin errors++; $display("FAIL rand%0d_v: got %b required %b", iter, V, m_v); end
    checks++;
    if (UUT.pc_q !== m_pc) begin errors++; $display("FAIL rand%0d_pc: got %h required %h", iter, UUT.pc_q, m_pc); end
    diffs = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] !== m_mem[a]) diffs++;
    checks++;
    if (diffs != 0) begin errors++; $display("FAIL rand%0d_mem: got %0d differing words required 0", iter, diffs); end
  endtask

  initial begin
    Reset = 1'b1;
    @(negedge Clk1);
    test_reset();
    test_sll_slh();
    test_overflow();
    test_load_store();
    test_branch(1'b1);
    test_branch(1'b0);
    test_jump();
    test_reset_mid_load();
    for (int n = 0; n < 12; n++) test_random(n);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
